// File: rtl/tl_phase_controller_if.sv
// Signal bundle between the intersection phase controller and its countdown
// counter and lamp drivers.
interface tl_phase_controller_if #(
    parameter int pINIT_WIDTH = 3
);
    logic                   last;
    logic                   flash_mode;
    logic [pINIT_WIDTH-1:0] init;
    logic                   en;
    logic [2:0]             light_ns;
    logic [2:0]             light_ew;
    logic [2:0]             phase;

    modport master (
        input  last,
        input  flash_mode,
        output init,
        output en,
        output light_ns,
        output light_ew,
        output phase
    );

    modport slave (
        output last,
        output flash_mode,
        input  init,
        input  en,
        input  light_ns,
        input  light_ew,
        input  phase
    );
endinterface

// File: rtl/tl_phase_controller.sv
// Four-phase two-road traffic light sequencer with tick prescaler, counter
// load strobes and a synchronised blinking-yellow override.
module tl_phase_controller #(
    parameter int pTICK_DIV   = 50_000_000,
    parameter int pTICK_WIDTH = 26,
    parameter int pINIT_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tl_phase_controller_if.master bus
);

    typedef enum logic [2:0] {
        NS_GRN = 3'd0,
        NS_YEL = 3'd1,
        EW_GRN = 3'd2,
        EW_YEL = 3'd3,
        FLASH  = 3'd4
    } state_t;

    localparam logic [pINIT_WIDTH-1:0] INIT_NONE = {pINIT_WIDTH{1'b0}};
    localparam logic [pINIT_WIDTH-1:0] LOAD_GRN  = pINIT_WIDTH'(32'd1);
    localparam logic [pINIT_WIDTH-1:0] LOAD_YEL  = pINIT_WIDTH'(32'd2);
    localparam logic [pTICK_WIDTH-1:0] TICK_MAX  = pTICK_WIDTH'(pTICK_DIV - 32'sd1);

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_RED = 3'b100;

    state_t                 state_r;
    state_t                 state_s;
    logic [pINIT_WIDTH-1:0] init_r;
    logic [pINIT_WIDTH-1:0] init_s;
    logic [pTICK_WIDTH-1:0] tick_cnt_r;
    logic                   tick_wrap_s;
    logic                   blink_r;
    logic                   blink_s;
    logic [1:0]             flash_sync_r;
    logic                   flash_s;
    logic [2:0]             light_ns_r;
    logic [2:0]             light_ew_r;
    logic [2:0]             light_ns_s;
    logic [2:0]             light_ew_s;

    assign flash_s     = flash_sync_r[1];
    assign tick_wrap_s = (tick_cnt_r == TICK_MAX);

    // A tick is suppressed during a load cycle so the counter never sees load and decrement together.
    assign bus.en       = tick_wrap_s && (init_r == INIT_NONE) && (state_r != FLASH);
    assign bus.init     = init_r;
    assign bus.phase    = state_r;
    assign bus.light_ns = light_ns_r;
    assign bus.light_ew = light_ew_r;

    // Two-flop synchroniser for the asynchronous flash request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_sync_r <= 2'b00;
        end else begin
            flash_sync_r <= {flash_sync_r[0], bus.flash_mode};
        end
    end

    // Prescaler: restarts on every counter load so each phase gets whole ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= {pTICK_WIDTH{1'b0}};
        end else if (init_r != INIT_NONE) begin
            tick_cnt_r <= {pTICK_WIDTH{1'b0}};
        end else if (tick_wrap_s) begin
            tick_cnt_r <= {pTICK_WIDTH{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + pTICK_WIDTH'(32'd1);
        end
    end

    // Next-state logic; the flash override wins over any pending advance or load.
    always_comb begin
        state_s = state_r;
        init_s  = INIT_NONE;
        blink_s = 1'b0;
        if (flash_s) begin
            state_s = FLASH;
            if (state_r == FLASH) begin
                blink_s = blink_r ^ tick_wrap_s;
            end else begin
                blink_s = 1'b1;
            end
        end else if (state_r == FLASH) begin
            state_s = NS_YEL;
            init_s  = LOAD_YEL;
        end else if (bus.last && (init_r == INIT_NONE)) begin
            case (state_r)
                NS_GRN: begin
                    state_s = NS_YEL;
                    init_s  = LOAD_YEL;
                end
                NS_YEL: begin
                    state_s = EW_GRN;
                    init_s  = LOAD_GRN;
                end
                EW_GRN: begin
                    state_s = EW_YEL;
                    init_s  = LOAD_YEL;
                end
                EW_YEL: begin
                    state_s = NS_GRN;
                    init_s  = LOAD_GRN;
                end
                default: begin
                    state_s = NS_YEL;
                    init_s  = LOAD_YEL;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Lamp decode from the next state so lamps and phase change on the same edge.
    always_comb begin
        light_ns_s = LAMP_RED;
        light_ew_s = LAMP_RED;
        case (state_s)
            NS_GRN: begin
                light_ns_s = LAMP_GRN;
                light_ew_s = LAMP_RED;
            end
            NS_YEL: begin
                light_ns_s = LAMP_YEL;
                light_ew_s = LAMP_RED;
            end
            EW_GRN: begin
                light_ns_s = LAMP_RED;
                light_ew_s = LAMP_GRN;
            end
            EW_YEL: begin
                light_ns_s = LAMP_RED;
                light_ew_s = LAMP_YEL;
            end
            FLASH: begin
                if (blink_s) begin
                    light_ns_s = LAMP_YEL;
                    light_ew_s = LAMP_YEL;
                end else begin
                    light_ns_s = LAMP_OFF;
                    light_ew_s = LAMP_OFF;
                end
            end
            default: begin
                light_ns_s = LAMP_RED;
                light_ew_s = LAMP_RED;
            end
        endcase
    end

    // Phase FSM with its registered strobe and lamp outputs; reset relies on the counter's yellow reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= NS_YEL;
            init_r     <= INIT_NONE;
            blink_r    <= 1'b0;
            light_ns_r <= LAMP_YEL;
            light_ew_r <= LAMP_RED;
        end else begin
            state_r    <= state_s;
            init_r     <= init_s;
            blink_r    <= blink_s;
            light_ns_r <= light_ns_s;
            light_ew_r <= light_ew_s;
        end
    end

endmodule

// File: tb/tb_tl_phase_controller.sv
// Directed bench for tl_phase_controller driving a behavioural countdown
// counter (green 15, yellow 3, red 18) with a 4-cycle tick.
module tb_tl_phase_controller;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    int   cyc;
    int   ens;
    int   ovl;
    logic lb;
    logic [2:0] i1;
    int   en_seen;

    logic [4:0] cnt;

    tl_phase_controller_if #(.pINIT_WIDTH(3)) bus ();

    tl_phase_controller #(
        .pTICK_DIV  (4),
        .pTICK_WIDTH(3),
        .pINIT_WIDTH(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Countdown counter model: load priority green > yellow > red, holds at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    cnt <= 5'd3;
        else if (bus.init[0])          cnt <= 5'd15;
        else if (bus.init[1])          cnt <= 5'd3;
        else if (bus.init[2])          cnt <= 5'd18;
        else if (bus.en && cnt != 5'd0) cnt <= cnt - 5'd1;
    end
    assign bus.last = (cnt == 5'd0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count edges until phase changes; also en pulses, en/init overlap, last before the change, init one edge in.
    task automatic measure(output int cycles, output int n_en, output int overlap,
                           output logic last_before, output logic [2:0] init_after1);
        logic [2:0] p0;
        p0          = bus.phase;
        cycles      = 0;
        n_en        = 0;
        overlap     = 0;
        last_before = 1'b0;
        init_after1 = 3'bxxx;
        while (bus.phase === p0 && cycles < 200) begin
            if (bus.en === 1'b1) n_en++;
            if (bus.en === 1'b1 && bus.init !== 3'b000) overlap++;
            last_before = bus.last;
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1) init_after1 = bus.init;
        end
    endtask

    task automatic boundary(input string tag, input logic [2:0] ph, input logic [2:0] ns,
                            input logic [2:0] ew, input logic [2:0] ini);
        check({tag, "_phase"}, bus.phase, ph);
        check({tag, "_ns"}, bus.light_ns, ns);
        check({tag, "_ew"}, bus.light_ew, ew);
        check({tag, "_init"}, bus.init, ini);
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        rst_n          = 1'b0;
        bus.flash_mode = 1'b0;

        // Reset state
        step(2);
        boundary("rst", 3'd1, 3'b010, 3'b100, 3'b000);
        check("rst_en", bus.en, 1'b0);
        rst_n = 1'b1;

        // First yellow from the counter's reset value
        measure(cyc, ens, ovl, lb, i1);
        check("start_cycles", cyc, 13);
        check("start_en_pulses", ens, 3);
        check("start_last", lb, 1'b1);
        boundary("to_ewg", 3'd2, 3'b100, 3'b001, 3'b001);
        check("stale_last_high", bus.last, 1'b1);

        // Full cycle
        measure(cyc, ens, ovl, lb, i1);
        check("ewg_cycles", cyc, 62);
        check("ewg_en", ens, 15);
        check("ewg_overlap", ovl, 0);
        check("ewg_init_1cyc", i1, 3'b000);
        boundary("to_ewy", 3'd3, 3'b100, 3'b010, 3'b010);

        measure(cyc, ens, ovl, lb, i1);
        check("ewy_cycles", cyc, 14);
        check("ewy_en", ens, 3);
        check("ewy_overlap", ovl, 0);
        check("ewy_init_1cyc", i1, 3'b000);
        boundary("to_nsg", 3'd0, 3'b001, 3'b100, 3'b001);

        measure(cyc, ens, ovl, lb, i1);
        check("nsg_cycles", cyc, 62);
        check("nsg_en", ens, 15);
        check("nsg_init_1cyc", i1, 3'b000);
        boundary("to_nsy", 3'd1, 3'b010, 3'b100, 3'b010);

        measure(cyc, ens, ovl, lb, i1);
        check("nsy_cycles", cyc, 14);
        check("nsy_en", ens, 3);
        check("nsy_init_1cyc", i1, 3'b000);
        boundary("to_ewg2", 3'd2, 3'b100, 3'b001, 3'b001);

        // Flash request mid EW_GRN
        step(10);
        bus.flash_mode = 1'b1;
        step(2);
        check("flash_sync_delay", bus.phase, 3'd2);
        step(1);
        boundary("flash_entry", 3'd4, 3'b010, 3'b010, 3'b000);
        check("flash_en", bus.en, 1'b0);
        step(3);
        check("blink_on_hold_ns", bus.light_ns, 3'b010);
        step(1);
        check("blink_off_ns", bus.light_ns, 3'b000);
        check("blink_off_ew", bus.light_ew, 3'b000);
        step(4);
        check("blink_on_again_ns", bus.light_ns, 3'b010);
        check("blink_on_again_ew", bus.light_ew, 3'b010);
        en_seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.en !== 1'b0) en_seen++;
            step(1);
        end
        check("flash_no_en", en_seen, 0);
        check("flash_still", bus.phase, 3'd4);

        // Leave flash
        bus.flash_mode = 1'b0;
        step(2);
        check("unflash_sync_delay", bus.phase, 3'd4);
        step(1);
        boundary("unflash", 3'd1, 3'b010, 3'b100, 3'b010);
        measure(cyc, ens, ovl, lb, i1);
        check("unflash_nsy_cycles", cyc, 14);
        check("unflash_init_1cyc", i1, 3'b000);
        boundary("unflash_to_ewg", 3'd2, 3'b100, 3'b001, 3'b001);

        // Reset pulse during NS_GRN
        measure(cyc, ens, ovl, lb, i1);
        check("pre_rst_ewg_cycles", cyc, 62);
        measure(cyc, ens, ovl, lb, i1);
        check("pre_rst_ewy_cycles", cyc, 14);
        check("pre_rst_phase", bus.phase, 3'd0);
        step(5);
        rst_n = 1'b0;
        #2;
        boundary("async_rst", 3'd1, 3'b010, 3'b100, 3'b000);
        check("async_rst_en", bus.en, 1'b0);
        step(2);
        rst_n = 1'b1;
        measure(cyc, ens, ovl, lb, i1);
        check("restart_cycles", cyc, 13);
        check("restart_en_pulses", ens, 3);
        check("restart_last", lb, 1'b1);
        boundary("restart_to_ewg", 3'd2, 3'b100, 3'b001, 3'b001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
